// File: rtl/giro_pkg.sv
// Shared encodings for the turn-signal flasher: lamp mode, flash phase and
// the decode from turn-FSM requests to a mode.
package giro_pkg;

    // Bit 0 drives the left lamp and bit 1 the right lamp, matching {x2,x1}.
    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_LEFT  = 2'b01,
        MODE_RIGHT = 2'b10,
        MODE_HAZ   = 2'b11
    } mode_t;

    localparam logic PH_OFF = 1'b0;
    localparam logic PH_ON  = 1'b1;

    localparam logic [3:0] FLASH_CNT_MAX = 4'hF;

    // Both direction requests at once decode naturally to HAZ via {x2,x1}.
    function automatic mode_t decode_request(input logic hazard,
                                             input logic x1,
                                             input logic x2);
        if (hazard) begin
            return MODE_HAZ;
        end
        return mode_t'({x2, x1});
    endfunction

endpackage

// File: rtl/giro_half_timer.sv
// Half-period counter: counts 0..HALF_PERIOD-1 while enabled, wraps to 0 on
// terminal count, and is forced to 0 by a synchronous clear.
module giro_half_timer
    import giro_pkg::*;
#(
    parameter int CNT_W       = 24,
    parameter int HALF_PERIOD = 12500000
) (
    input  logic clk,
    input  logic srst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF_PERIOD - 1);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    // Not qualified by en: the parent only looks at tc while enabling us,
    // and keeping it enable-free avoids a combinational loop through en.
    assign tc = (count_reg == LAST);

    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = '0;
        end else if (en) begin
            count_next = tc ? '0 : count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/giro_flasher.sv
// Turn-signal lamp flasher: blinks left/right/both lamps at a fixed half
// period, pulses click on each lamp transition and counts completed flashes.
module giro_flasher
    import giro_pkg::*;
#(
    parameter int HALF_PERIOD = 12500000,
    parameter int CNT_W       = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       x1,
    input  logic       x2,
    input  logic       hazard,
    output logic       lamp_l,
    output logic       lamp_r,
    output logic       click,
    output logic       active,
    output logic [3:0] flash_cnt
);

    mode_t      mode_reg, mode_next, req_mode;
    logic       phase_reg, phase_next;
    logic [3:0] flash_reg, flash_next;
    logic       click_reg, click_next;
    logic       active_reg, active_next;
    logic [1:0] lamp_reg, lamp_next;
    logic       timer_clr, timer_en, timer_tc;

    giro_half_timer #(
        .CNT_W       (CNT_W),
        .HALF_PERIOD (HALF_PERIOD)
    ) u_half_timer (
        .clk  (clk),
        .srst (rst),
        .clr  (timer_clr),
        .en   (timer_en),
        .tc   (timer_tc)
    );

    assign req_mode = decode_request(hazard, x1, x2);

    always_comb begin
        mode_next  = mode_reg;
        phase_next = phase_reg;
        flash_next = flash_reg;
        click_next = 1'b0;
        timer_clr  = 1'b0;
        timer_en   = 1'b0;

        if (req_mode != mode_reg) begin
            // Any mode change restarts the flash from the start of an ON half.
            mode_next  = req_mode;
            flash_next = '0;
            timer_clr  = 1'b1;
            if (req_mode != MODE_OFF) begin
                phase_next = PH_ON;
                click_next = 1'b1;
            end else begin
                phase_next = PH_OFF;
                click_next = |lamp_reg;
            end
        end else if (mode_reg != MODE_OFF) begin
            timer_en = 1'b1;
            if (timer_tc) begin
                phase_next = ~phase_reg;
                click_next = 1'b1;
                if (phase_reg == PH_ON && flash_reg != FLASH_CNT_MAX) begin
                    flash_next = flash_reg + 4'd1;
                end
            end
        end else begin
            timer_clr = 1'b1;
        end

        active_next = (mode_next != MODE_OFF);
    end

    // Lamp gi follows mode bit gi while the phase is ON.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lamp
            assign lamp_next[gi] = (phase_next == PH_ON) && mode_next[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_reg   <= MODE_OFF;
            phase_reg  <= PH_OFF;
            flash_reg  <= '0;
            click_reg  <= 1'b0;
            active_reg <= 1'b0;
            lamp_reg   <= '0;
        end else begin
            mode_reg   <= mode_next;
            phase_reg  <= phase_next;
            flash_reg  <= flash_next;
            click_reg  <= click_next;
            active_reg <= active_next;
            lamp_reg   <= lamp_next;
        end
    end

    assign lamp_l    = lamp_reg[0];
    assign lamp_r    = lamp_reg[1];
    assign click     = click_reg;
    assign active    = active_reg;
    assign flash_cnt = flash_reg;

endmodule

// File: doc/giro_flasher.md
Name: giro_flasher

Overview:
Turn-signal lamp flasher that sits directly downstream of the turn-indicator FSM. It consumes the FSM's steady direction requests x1 (left) and x2 (right) plus a hazard request, and drives blinking lamp outputs at a fixed half-period. It also emits a one-cycle click pulse on every lamp transition and a saturating flash count for the dashboard.

Parameters:
HALF_PERIOD, 12500000, clock cycles per ON or OFF half of a flash (legal range >= 2)
CNT_W, 24, width of the half-period counter (must satisfy 2**CNT_W >= HALF_PERIOD)

Ports:
clk  in  1  system clock; all logic on its rising edge
rst  in  1  synchronous, active-high reset
x1  in  1  left-turn request from the turn FSM (level)
x2  in  1  right-turn request from the turn FSM (level)
hazard  in  1  hazard request (level); overrides x1/x2
lamp_l  out  1  left lamp drive (registered)
lamp_r  out  1  right lamp drive (registered)
click  out  1  one-cycle pulse on every lamp ON/OFF transition (registered)
active  out  1  high while mode != OFF (registered)
flash_cnt  out  4  completed ON phases since the current mode started; saturates at 15

Behaviour:
- One clock; reset is synchronous and active-high; clock port clk, reset port rst.
- Reset: lamp_l=0, lamp_r=0, click=0, active=0, flash_cnt=0, mode=OFF, phase=OFF, counter=0. Reset asserted mid-flash wins over everything on that edge.
- Requested mode (combinational): hazard=1 or (x1=1 and x2=1) -> HAZ; else x1=1 -> LEFT; else x2=1 -> RIGHT; else OFF.
- The requested mode is compared with the registered mode on each edge.
- Mode change to non-OFF (including LEFT<->RIGHT, any<->HAZ):
  - mode updates, phase=ON, counter=0, flash_cnt=0, click=1, all on the same edge.
  - Lamps reflect the new mode after that edge (1-cycle latency from request).
- Mode change to OFF: on that edge lamps go 0, phase=OFF, counter=0, active=0, flash_cnt=0. click=1 only if any lamp was on; otherwise click=0.
- Mode unchanged and non-OFF:
  - counter increments each cycle.
  - When counter==HALF_PERIOD-1: counter wraps to 0, phase toggles, click=1.
  - On ON->OFF toggles, flash_cnt increments (saturating at 15).
  - Each half lasts exactly HALF_PERIOD cycles.
- Lamp mapping while phase=ON: LEFT -> lamp_l=1; RIGHT -> lamp_r=1; HAZ -> both=1. phase=OFF -> both 0.
- click is high for exactly one cycle per event and is 0 otherwise.
- Mode unchanged and OFF: counter held at 0; all outputs 0.
- Request glitch of one cycle: this is still a mode change; the flash restarts. No filtering; upstream is clean.

Decomposition:
- Shared package giro_pkg:
  - Mode encoding MODE_OFF=2'b00, MODE_LEFT=2'b01, MODE_RIGHT=2'b10, MODE_HAZ=2'b11, matching {x2,x1} so the FSM outputs map directly.
  - Phase constants PH_OFF=0, PH_ON=1.
- One sub-module, giro_half_timer:
  - Parameterised CNT_W/HALF_PERIOD counter with synchronous clear input and a terminal-count output (wraps to 0 on terminal).
  - giro_flasher instantiates it once and keeps the mode/phase/flash_cnt logic.

Test Plan (HALF_PERIOD=4):
- Reset: hold rst 3 cycles with x1=1 -> all outputs 0 throughout. Release -> lamp_l=1, click=1, active=1 after the first edge.
- Left flashing: x1=1 for 20 cycles -> lamp_l pattern 1111 0000 1111 0000 1111, lamp_r=0, click pulses every 4 cycles, flash_cnt reaches 2.
- Direction swap mid-ON: x1=1 for 2 cycles, then x2=1 -> next edge lamp_l=0, lamp_r=1, click=1, flash_cnt=0, then 4 full ON cycles.
- Hazard override: x1=1 and hazard=1 -> both lamps blink together. Drop hazard at cycle 6 -> next edge restarts as LEFT with lamp_l=1 only. Also x1=x2=1 without hazard -> identical to hazard.
- Cancel: x1 drops during ON at cycle 2 -> next edge lamps 0, click=1, active=0. Cancel during OFF phase -> click stays 0.
- Saturation and mid-run reset: x2=1 for 140 cycles -> flash_cnt sticks at 15. Then rst for 1 cycle with x2 still 1 -> all outputs 0 on that edge, then flashing restarts with flash_cnt=0.
